// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// ----------------------------------------------------------------------------
// Decode-and-sequencing stage between fetch and execute. Decodes one
// instruction per accepted handshake into a registered control bundle for
// execute. It expands the following instructions into micro-ops:
//   - LW post-increment (custom-1 opcode 0101011): two micro-ops on a single
//     write port.
//   - CSRRW and MRET: the sequencer stays busy for a CSR settle time.
//
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to report illegal
// instructions. The sequencer then emits a valid bubble with illegal_o=1.
// When the macro is undefined, an illegal word produces an invalid bubble and
// illegal_o stays 0.
//
// Parameters
//   WB_PORTS      register-file write ports (1 or 2). With 2 ports, the
//                 post-increment load issues as one bundle using wd2_en_o.
//   POSTINC_STEP  value added to rs1 by the post-increment load.
//   CSR_LAT       total cycles a CSRRW/MRET occupies the sequencer (>=1).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   instr_i             instruction word
//   instr_valid_i       instr_i valid
//   ready_o             sequencer can accept an instruction (state DECODE)
//   stall_i             execute not ready; every register holds
//   flush_i             redirect; kills in-flight and pending work
//   valid_o .. illegal_o registered control bundle
//   imm_o               immediate for the bundle (POSTINC_STEP on uop1)
//   state_o             debug view of the sequencer state
//
// Handshake: an instruction is taken on a rising edge only when all of the
// following are true at that edge: instr_valid_i, ready_o, !stall_i, !flush_i.
// The resulting bundle is visible from that edge on. Fetch must hold instr_i
// until it is taken. While stall_i is high, the bundle presented to execute
// stays unchanged.
// ----------------------------------------------------------------------------
module ctrl_sequencer #(
  parameter int WB_PORTS     = 1,
  parameter int POSTINC_STEP = 4,
  parameter int CSR_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [3:0]  aluop_o,
  output logic        rf_en_o,
  output logic        sel_a_o,
  output logic        sel_b_o,
  output logic        rd_en_o,
  output logic        wr_en_o,
  output logic        jump_o,
  output logic        is_mret_o,
  output logic        csr_rd_o,
  output logic        csr_wr_o,
  output logic        sel_laddr_o,
  output logic        wd2_en_o,
  output logic [1:0]  sel_wb_o,
  output logic [2:0]  mem_mode_o,
  output logic [2:0]  br_type_o,
  output logic        rd_sel_o,
  output logic        uop_o,
  output logic        illegal_o,
  output logic [31:0] imm_o,
  output logic [1:0]  state_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NULL = 4'd10;

  localparam int CW = (CSR_LAT > 1) ? $clog2(CSR_LAT) : 1;

  typedef enum logic [1:0] {
    S_DECODE   = 2'd0,
    S_POSTINC2 = 2'd1,
    S_CSR_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic        rf_en;
    logic        sel_a;
    logic        sel_b;
    logic        rd_en;
    logic        wr_en;
    logic        jump;
    logic        is_mret;
    logic        csr_rd;
    logic        csr_wr;
    logic        sel_laddr;
    logic        wd2_en;
    logic [1:0]  sel_wb;
    logic [2:0]  mem_mode;
    logic [2:0]  br_type;
    logic        rd_sel;
    logic        uop;
    logic        illegal;
    logic [31:0] imm;
  } bundle_t;

  // Bubble: every strobe inactive, with neutral encodings for the
  // multi-bit fields.
  function automatic bundle_t bubble();
    bundle_t b;
    b          = '0;
    b.aluop    = ALU_ADD;
    b.sel_wb   = 2'b00;
    b.mem_mode = 3'b111;
    b.br_type  = 3'b010;
    return b;
  endfunction

  // Maps funct3 to an ALU operation. alt selects SUB/SRA.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  bundle_t dec;
  logic    dec_ok, dec_postinc, dec_csr;

  always_comb begin
    dec         = bubble();
    dec.valid   = 1'b1;
    dec_ok      = 1'b1;
    dec_postinc = 1'b0;
    dec_csr     = 1'b0;
    case (opc)
      7'b0110011: begin // R-type
        dec_ok    = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        dec.aluop = alu_of(f3, f7[5]);
        dec.rf_en = 1'b1;
      end
      7'b0010011: begin // I-ALU; only the shifts constrain funct7
        if (f3 == 3'b001) dec_ok = (f7 == 7'b0000000);
        if (f3 == 3'b101) dec_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        dec.aluop = alu_of(f3, (f3 == 3'b101) && f7[5]);
        dec.sel_b = 1'b1;
        dec.rf_en = 1'b1;
        dec.imm   = imm_i;
      end
      7'b0000011: begin // loads
        dec_ok = 1'b1;
        case (f3)
          3'b000:  dec.mem_mode = 3'b000;
          3'b001:  dec.mem_mode = 3'b001;
          3'b010:  dec.mem_mode = 3'b010;
          3'b100:  dec.mem_mode = 3'b011;
          3'b101:  dec.mem_mode = 3'b100;
          default: dec_ok = 1'b0;
        endcase
        dec.rf_en  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.rd_en  = 1'b1;
        dec.sel_wb = 2'b01;
        dec.imm    = imm_i;
      end
      7'b0100011: begin // stores
        dec_ok       = (f3 <= 3'b010);
        dec.wr_en    = 1'b1;
        dec.sel_b    = 1'b1;
        dec.mem_mode = f3;
        dec.imm      = imm_s;
      end
      7'b1100011: begin // branches: ALU compares, br_type carries the condition
        dec_ok      = (f3 != 3'b010) && (f3 != 3'b011);
        dec.aluop   = ALU_SUB;
        dec.br_type = f3;
        dec.imm     = imm_b;
      end
      7'b1101111: begin // JAL: ALU forms PC+imm, writeback takes PC+4
        dec.rf_en  = 1'b1;
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.jump   = 1'b1;
        dec.sel_wb = 2'b10;
        dec.imm    = imm_j;
      end
      7'b1100111: begin // JALR
        dec_ok     = (f3 == 3'b000);
        dec.rf_en  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.jump   = 1'b1;
        dec.sel_wb = 2'b10;
        dec.imm    = imm_i;
      end
      7'b0110111: begin // LUI: ALU passes operand B through
        dec.aluop = ALU_NULL;
        dec.sel_b = 1'b1;
        dec.rf_en = 1'b1;
        dec.imm   = imm_u;
      end
      7'b0010111: begin // AUIPC
        dec.sel_a = 1'b1;
        dec.sel_b = 1'b1;
        dec.rf_en = 1'b1;
        dec.imm   = imm_u;
      end
      7'b1110011: begin // SYSTEM: only MRET and CSRRW are supported
        if (instr_i == 32'h3020_0073) begin
          dec.is_mret = 1'b1;
          dec.imm     = imm_i;
          dec_csr     = 1'b1;
        end else if (f3 == 3'b001) begin
          dec.csr_rd = 1'b1;
          dec.csr_wr = 1'b1;
          dec.rf_en  = 1'b1;
          dec.sel_wb = 2'b11;
          dec.imm    = imm_i;
          dec_csr    = 1'b1;
        end else begin
          dec_ok = 1'b0;
        end
      end
      7'b0101011: begin // LW post-increment: address comes straight from rs1
        dec_ok        = (f3 == 3'b010);
        dec.rf_en     = 1'b1;
        dec.rd_en     = 1'b1;
        dec.sel_laddr = 1'b1;
        dec.sel_wb    = 2'b01;
        dec.mem_mode  = 3'b010;
        dec.wd2_en    = (WB_PORTS == 2);
        dec.imm       = imm_i;
        dec_postinc   = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase

    if (!dec_ok) begin
      dec         = bubble();
      dec_postinc = 1'b0;
      dec_csr     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
`else
      dec.valid   = 1'b0;
      dec.illegal = 1'b0;
`endif
    end
  end

  // Second micro-op of the post-increment load. It writes rs1 + POSTINC_STEP
  // back to rs1.
  function automatic bundle_t uop1_bundle();
    bundle_t b;
    b        = bubble();
    b.valid  = 1'b1;
    b.rf_en  = 1'b1;
    b.sel_b  = 1'b1;
    b.aluop  = ALU_ADD;
    b.rd_sel = 1'b1;
    b.uop    = 1'b1;
    b.imm    = 32'(POSTINC_STEP);
    return b;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  bundle_t        out_q, out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (flush_i) begin
      state_d = S_DECODE;
      cnt_d   = '0;
      out_d   = bubble();
    end else if (!stall_i) begin
      out_d = bubble();
      case (state_q)
        S_DECODE: begin
          if (instr_valid_i) begin
            out_d = dec;
            if (dec_postinc && (WB_PORTS == 1)) begin
              state_d = S_POSTINC2;
            end else if (dec_csr && (CSR_LAT > 1)) begin
              state_d = S_CSR_WAIT;
              cnt_d   = CW'(CSR_LAT - 1);
            end
          end
        end
        S_POSTINC2: begin
          out_d   = uop1_bundle();
          state_d = S_DECODE;
        end
        S_CSR_WAIT: begin
          // Each wait cycle emits a bubble. The last one hands back to DECODE.
          if (cnt_q <= CW'(1)) begin
            state_d = S_DECODE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DECODE;
      cnt_q   <= '0;
      out_q   <= bubble();
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign ready_o     = (state_q == S_DECODE);
  assign state_o     = state_q;
  assign valid_o     = out_q.valid;
  assign aluop_o     = out_q.aluop;
  assign rf_en_o     = out_q.rf_en;
  assign sel_a_o     = out_q.sel_a;
  assign sel_b_o     = out_q.sel_b;
  assign rd_en_o     = out_q.rd_en;
  assign wr_en_o     = out_q.wr_en;
  assign jump_o      = out_q.jump;
  assign is_mret_o   = out_q.is_mret;
  assign csr_rd_o    = out_q.csr_rd;
  assign csr_wr_o    = out_q.csr_wr;
  assign sel_laddr_o = out_q.sel_laddr;
  assign wd2_en_o    = out_q.wd2_en;
  assign sel_wb_o    = out_q.sel_wb;
  assign mem_mode_o  = out_q.mem_mode;
  assign br_type_o   = out_q.br_type;
  assign rd_sel_o    = out_q.rd_sel;
  assign uop_o       = out_q.uop;
  assign illegal_o   = out_q.illegal;
  assign imm_o       = out_q.imm;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer. It runs two instances side by side:
//   - a: one write port, step 4, CSR_LAT 3
//   - b: two write ports, step 4, CSR_LAT 1
// Both instances see the same directed stimulus. A per-instance model
// predicts each bundle from the instruction semantics. It keeps a queue of
// the outputs still owed for the current instruction. Literal checks pin the
// model at key points.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic        rf_en, sel_a, sel_b, rd_en, wr_en, jump, mret, csr_rd, csr_wr, laddr, wd2;
    logic [1:0]  sel_wb;
    logic [2:0]  mem, br;
    logic        rd_sel, uop, ill;
    logic [31:0] imm;
  } exp_t;
  typedef exp_t exp_list_t[$];

  // funct3 -> ALU code; the alternate (funct7[5]) forms are the next code up.
  localparam logic [31:0] ALU_TAB = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = '0;
  logic        instr_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;

  always #5 clk = ~clk;

  logic        rdy_a, vld_a, rf_a, sa_a, sb_a, rde_a, wr_a, jmp_a, mret_a, crd_a, cwr_a, la_a, wd2_a, rs_a, uop_a, ill_a;
  logic [3:0]  alu_a;
  logic [1:0]  wb_a, st_a;
  logic [2:0]  mm_a, br_a;
  logic [31:0] imm_a;
  logic        rdy_b, vld_b, rf_b, sa_b, sb_b, rde_b, wr_b, jmp_b, mret_b, crd_b, cwr_b, la_b, wd2_b, rs_b, uop_b, ill_b;
  logic [3:0]  alu_b;
  logic [1:0]  wb_b, st_b;
  logic [2:0]  mm_b, br_b;
  logic [31:0] imm_b;

  ctrl_sequencer #(.WB_PORTS(1), .POSTINC_STEP(4), .CSR_LAT(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .ready_o(rdy_a), .stall_i(stall_i), .flush_i(flush_i), .valid_o(vld_a),
    .aluop_o(alu_a), .rf_en_o(rf_a), .sel_a_o(sa_a), .sel_b_o(sb_a), .rd_en_o(rde_a),
    .wr_en_o(wr_a), .jump_o(jmp_a), .is_mret_o(mret_a), .csr_rd_o(crd_a), .csr_wr_o(cwr_a),
    .sel_laddr_o(la_a), .wd2_en_o(wd2_a), .sel_wb_o(wb_a), .mem_mode_o(mm_a),
    .br_type_o(br_a), .rd_sel_o(rs_a), .uop_o(uop_a), .illegal_o(ill_a), .imm_o(imm_a),
    .state_o(st_a));

  ctrl_sequencer #(.WB_PORTS(2), .POSTINC_STEP(4), .CSR_LAT(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .ready_o(rdy_b), .stall_i(stall_i), .flush_i(flush_i), .valid_o(vld_b),
    .aluop_o(alu_b), .rf_en_o(rf_b), .sel_a_o(sa_b), .sel_b_o(sb_b), .rd_en_o(rde_b),
    .wr_en_o(wr_b), .jump_o(jmp_b), .is_mret_o(mret_b), .csr_rd_o(crd_b), .csr_wr_o(cwr_b),
    .sel_laddr_o(la_b), .wd2_en_o(wd2_b), .sel_wb_o(wb_b), .mem_mode_o(mm_b),
    .br_type_o(br_b), .rd_sel_o(rs_b), .uop_o(uop_b), .illegal_o(ill_b), .imm_o(imm_b),
    .state_o(st_b));

  exp_t act_a, act_b;
  always_comb begin
    act_a.valid = vld_a; act_a.aluop = alu_a; act_a.rf_en = rf_a; act_a.sel_a = sa_a;
    act_a.sel_b = sb_a; act_a.rd_en = rde_a; act_a.wr_en = wr_a; act_a.jump = jmp_a;
    act_a.mret = mret_a; act_a.csr_rd = crd_a; act_a.csr_wr = cwr_a; act_a.laddr = la_a;
    act_a.wd2 = wd2_a; act_a.sel_wb = wb_a; act_a.mem = mm_a; act_a.br = br_a;
    act_a.rd_sel = rs_a; act_a.uop = uop_a; act_a.ill = ill_a; act_a.imm = imm_a;
    act_b.valid = vld_b; act_b.aluop = alu_b; act_b.rf_en = rf_b; act_b.sel_a = sa_b;
    act_b.sel_b = sb_b; act_b.rd_en = rde_b; act_b.wr_en = wr_b; act_b.jump = jmp_b;
    act_b.mret = mret_b; act_b.csr_rd = crd_b; act_b.csr_wr = cwr_b; act_b.laddr = la_b;
    act_b.wd2 = wd2_b; act_b.sel_wb = wb_b; act_b.mem = mm_b; act_b.br = br_b;
    act_b.rd_sel = rs_b; act_b.uop = uop_b; act_b.ill = ill_b; act_b.imm = imm_b;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  function automatic exp_t bubble_m();
    exp_t b;
    b     = '0;
    b.mem = 3'd7;
    b.br  = 3'd2;
    return b;
  endfunction

  // Every cycle of output one accepted instruction produces, in order.
  function automatic exp_list_t expand(input logic [31:0] ins, input int wb, input int step, input int lat);
    exp_list_t l;
    exp_t b, u;
    bit ok, pi, csr, alt;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] ii;
    int v;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ii = 32'($signed(ins) >>> 20);
    b = bubble_m(); b.valid = 1'b1; ok = 1'b1; pi = 1'b0; csr = 1'b0; alt = 1'b0;
    case (op)
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        alt = (f7 == 7'h20);
        b.aluop = ALU_TAB[int'(f3)*4 +: 4] + 4'(alt); b.rf_en = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        alt = (f3 == 3'd5) && (f7 == 7'h20);
        b.aluop = ALU_TAB[int'(f3)*4 +: 4] + 4'(alt); b.sel_b = 1'b1; b.rf_en = 1'b1; b.imm = ii;
      end
      7'h03: begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        b.mem = (f3 < 3'd4) ? f3 : f3 - 3'd1;
        b.rf_en = 1'b1; b.sel_b = 1'b1; b.rd_en = 1'b1; b.sel_wb = 2'd1; b.imm = ii;
      end
      7'h23: begin
        ok = (f3 < 3'd3); b.wr_en = 1'b1; b.sel_b = 1'b1; b.mem = f3;
        b.imm = {ii[31:5], ins[11:7]};
      end
      7'h63: begin
        ok = (f3 != 3'd2) && (f3 != 3'd3); b.br = f3; b.aluop = 4'd1;
        v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        b.imm = 32'(v);
      end
      7'h6F: begin
        b.rf_en = 1'b1; b.sel_a = 1'b1; b.sel_b = 1'b1; b.jump = 1'b1; b.sel_wb = 2'd2;
        v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        b.imm = 32'(v);
      end
      7'h67: begin
        ok = (f3 == 3'd0); b.rf_en = 1'b1; b.sel_b = 1'b1; b.jump = 1'b1; b.sel_wb = 2'd2; b.imm = ii;
      end
      7'h37: begin b.aluop = 4'd10; b.sel_b = 1'b1; b.rf_en = 1'b1; b.imm = ins & 32'hFFFF_F000; end
      7'h17: begin b.sel_a = 1'b1; b.sel_b = 1'b1; b.rf_en = 1'b1; b.imm = ins & 32'hFFFF_F000; end
      7'h73: begin
        if (ins == 32'h3020_0073) begin b.mret = 1'b1; b.imm = ii; csr = 1'b1; end
        else if (f3 == 3'd1) begin
          b.csr_rd = 1'b1; b.csr_wr = 1'b1; b.rf_en = 1'b1; b.sel_wb = 2'd3; b.imm = ii; csr = 1'b1;
        end else ok = 1'b0;
      end
      7'h2B: begin
        ok = (f3 == 3'd2); b.laddr = 1'b1; b.rf_en = 1'b1; b.rd_en = 1'b1; b.sel_wb = 2'd1;
        b.mem = 3'd2; b.wd2 = (wb == 2); b.imm = ii; pi = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b = bubble_m(); pi = 1'b0; csr = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      b.valid = 1'b1; b.ill = 1'b1;
`else
      b.valid = 1'b0;
`endif
    end
    l.push_back(b);
    if (pi && wb == 1) begin
      u = bubble_m(); u.valid = 1'b1; u.rf_en = 1'b1; u.sel_b = 1'b1; u.rd_sel = 1'b1;
      u.uop = 1'b1; u.imm = 32'(step);
      l.push_back(u);
    end
    if (csr) for (int k = 1; k < lat; k++) l.push_back(bubble_m());
    return l;
  endfunction

  exp_t cur_a, cur_b;
  exp_list_t pend_a, pend_b, lst_a, lst_b;

  always @(posedge clk) begin
    if (!rst_n || flush_i) begin
      cur_a = bubble_m(); pend_a.delete();
      cur_b = bubble_m(); pend_b.delete();
    end else if (!stall_i) begin
      if (pend_a.size() > 0) cur_a = pend_a.pop_front();
      else if (instr_valid_i) begin
        lst_a = expand(instr_i, 1, 4, 3); cur_a = lst_a.pop_front(); pend_a = lst_a;
      end else cur_a = bubble_m();
      if (pend_b.size() > 0) cur_b = pend_b.pop_front();
      else if (instr_valid_i) begin
        lst_b = expand(instr_i, 2, 4, 1); cur_b = lst_b.pop_front(); pend_b = lst_b;
      end else cur_b = bubble_m();
    end
  end

  // Per-cycle compare, on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (act_a !== cur_a) begin n_err++; $display("FAIL bundle_a t=%0t got %h want %h", $time, act_a, cur_a); end
      n_cmp++;
      if (rdy_a !== (pend_a.size() == 0)) begin n_err++; $display("FAIL ready_a t=%0t got %b want %b", $time, rdy_a, pend_a.size() == 0); end
      n_cmp++;
      if ((st_a != 2'd0) !== (pend_a.size() != 0)) begin n_err++; $display("FAIL state_a t=%0t got %0d pending %0d", $time, st_a, pend_a.size()); end
      n_cmp++;
      if (act_b !== cur_b) begin n_err++; $display("FAIL bundle_b t=%0t got %h want %h", $time, act_b, cur_b); end
      n_cmp++;
      if (rdy_b !== (pend_b.size() == 0)) begin n_err++; $display("FAIL ready_b t=%0t got %b want %b", $time, rdy_b, pend_b.size() == 0); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    @(negedge clk);
    rst_n = 1'b1; instr_i = ins; instr_valid_i = v; stall_i = st; flush_i = fl;
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    rst_n = 1'b0; instr_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [31:0] I_SRAI = 32'h4033_5293;
  localparam logic [31:0] I_PI   = 32'h0040_A12B;
  localparam logic [31:0] I_CSR  = 32'h3001_10F3;
  localparam logic [31:0] I_MRET = 32'h3020_0073;
  localparam logic [31:0] I_ILL  = 32'hFFFF_FFFF;

  logic [31:0] vec [12];

  initial begin
    vec = '{32'h00C5_8533, 32'h40C5_8533, 32'h0045_A503, 32'h00B5_2223,
            32'hFE20_8EE3, 32'h0080_00EF, 32'h0000_8067, 32'h1234_52B7,
            32'h0000_1517, 32'h0005_C503, I_PI, 32'h00B5_3023};

    rst_cyc();
    chk_en = 1'b1;
    rst_cyc();
    chk("reset_valid", vld_a, 0);
    chk("reset_mem_mode", mm_a, 3'b111);
    chk("reset_br_type", br_a, 3'b010);
    chk("reset_illegal", ill_a, 0);

    cyc(I_SRAI, 1, 0, 0);
    chk("srai_valid", vld_a, 1);
    chk("srai_aluop", alu_a, 7);
    chk("srai_sel_b", sb_a, 1);
    chk("srai_rf_en", rf_a, 1);
    chk("srai_imm", imm_a, 32'h403);

    cyc(I_PI, 1, 0, 0);
    chk("pi_uop0_laddr", la_a, 1);
    chk("pi_uop0_sel_wb", wb_a, 2'b01);
    chk("pi_uop0_rd_sel", rs_a, 0);
    chk("pi_uop0_ready", rdy_a, 0);
    chk("pi2_wd2", wd2_b, 1);
    chk("pi2_ready", rdy_b, 1);
    cyc(0, 0, 0, 0);
    chk("pi_uop1_aluop", alu_a, 0);
    chk("pi_uop1_rd_sel", rs_a, 1);
    chk("pi_uop1_uop", uop_a, 1);
    chk("pi_uop1_imm", imm_a, 4);
    chk("pi_uop1_ready", rdy_a, 1);
    chk("pi2_single", vld_b, 0);
    cyc(0, 0, 0, 0);

    cyc(I_CSR, 1, 0, 0);
    chk("csr_rd", crd_a, 1);
    chk("csr_wr", cwr_a, 1);
    chk("csr_sel_wb", wb_a, 2'b11);
    chk("csr_ready0", rdy_a, 0);
    cyc(0, 0, 0, 0);
    chk("csr_ready1", rdy_a, 0);
    chk("csr_bubble", vld_a, 0);
    cyc(0, 0, 0, 0);
    chk("csr_ready2", rdy_a, 1);
    cyc(I_MRET, 1, 0, 0);
    chk("mret_flag", mret_a, 1);
    chk("mret_b_ready", rdy_b, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(I_PI, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("stall_hold_laddr", la_a, 1);
    chk("stall_hold_valid", vld_a, 1);
    chk("stall_hold_ready", rdy_a, 0);
    cyc(0, 0, 0, 1);
    chk("flush_valid", vld_a, 0);
    chk("flush_ready", rdy_a, 1);
    cyc(0, 0, 0, 0);
    chk("flush_no_uop1", uop_a, 0);

    cyc(I_ILL, 1, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("illegal_flag", ill_a, 1);
    chk("illegal_valid", vld_a, 1);
`else
    chk("illegal_flag", ill_a, 0);
    chk("illegal_valid", vld_a, 0);
`endif
    cyc(0, 0, 0, 0);
    chk("illegal_one_cycle", ill_a, 0);

    cyc(I_SRAI, 1, 0, 1);
    chk("flush_drop", vld_a, 0);

    cyc(I_CSR, 1, 0, 0);
    cyc(0, 0, 0, 0);
    rst_cyc();
    chk("reset_mid_csr_ready", rdy_a, 1);
    chk("reset_mid_csr_valid", vld_a, 0);

    cyc(I_CSR, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 12; i++) cyc(vec[i], 1, 0, 0);
    cyc(I_CSR, 1, 0, 0);
    cyc(I_PI, 1, 0, 0);
    cyc(I_PI, 1, 0, 0);
    cyc(I_MRET, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Registered, parametrised decode-and-sequencing unit for the pipelined RISC-V core. Sits between fetch and execute: decodes one instruction per accepted handshake into the full control bundle and registers it for the execute stage. Expands multi-cycle instructions into micro-ops: post-increment load on a single write port, and CSR/MRET settle time. Honours downstream stall and pipeline flush.

## Interface
- `WB_PORTS`, 1: register-file write ports; 1 or 2. 2 = post-increment load in one op via `wd2_en_o`.
- `POSTINC_STEP`, 4: increment added to rs1 by post-increment load.
- `CSR_LAT`, 2: total cycles a CSRRW/MRET occupies the sequencer (≥1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_i` in 32: instruction word.
- `instr_valid_i` in 1: `instr_i` valid.
- `ready_o` out 1: sequencer can accept an instruction.
- `stall_i` in 1: execute stage not ready; hold outputs.
- `flush_i` in 1: branch/trap redirect; kill in-flight and pending work.
- `valid_o` out 1: control bundle valid.
- `aluop_o` out 4: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, NULL=10.
- `rf_en_o`, `sel_a_o`, `sel_b_o`, `rd_en_o`, `wr_en_o`, `jump_o`, `is_mret_o`, `csr_rd_o`, `csr_wr_o`, `sel_laddr_o`, `wd2_en_o` out 1 each: control strobes.
- `sel_wb_o` out 2: 00 ALU, 01 memory, 10 PC+4, 11 CSR.
- `mem_mode_o` out 3: 000 B, 001 H, 010 W, 011 BU, 100 HU, 111 none.
- `br_type_o` out 3: funct3 for branches; 3'b010 = no branch.
- `rd_sel_o` out 1: write index 0 = rd, 1 = rs1.
- `uop_o` out 1: micro-op index of current bundle.
- `illegal_o` out 1: undecodable instruction.

## Operation
- Accept: `instr_valid_i && ready_o && !stall_i && !flush_i`. `ready_o = (state==DECODE)`.
- Default bundle (bubble, reset, unlisted fields): all strobes 0, `aluop_o`=ADD, `sel_wb_o`=00, `mem_mode_o`=111, `br_type_o`=010. Never hold stale fields.
- Decode: R-type, I-ALU (SRAI→SRA, SRLI→SRL), loads, stores, branches, JAL, JALR, LUI (NULL, sel_b), AUIPC, SYSTEM 1110011 (funct3 000 MRET, 001 CSRRW), custom 0101011 LW-post-increment. Other opcodes/funct combos = illegal.
- FSM states: DECODE, POSTINC2, CSR_WAIT.
  - DECODE→POSTINC2: accepted LW-post-inc with `WB_PORTS==1`. uop0 = load word to rd, `sel_laddr_o`=1, `sel_wb_o`=01, `rd_en_o`=1, `mem_mode_o`=010.
  - POSTINC2→DECODE: emits uop1 = `rf_en_o`=1, `sel_b_o`=1, ADD, `sel_wb_o`=00, `rd_sel_o`=1, `uop_o`=1, with immediate path forced to `POSTINC_STEP`.
  - `WB_PORTS==2`: single bundle, uop0 fields plus `wd2_en_o`=1; stays in DECODE.
  - DECODE→CSR_WAIT: accepted CSRRW/MRET when `CSR_LAT>1`; counter loaded `CSR_LAT-1`; bubbles until counter reaches 0, then DECODE.
- Stall: all output registers, state and counter hold (flush excepted).
- Flush: highest priority. Next edge: `valid_o`=0, bubble, state=DECODE, counter cleared; a same-cycle instruction is dropped.

## Timing
- Decode latency 1: accepted at edge N, bundle visible after edge N.
- Post-increment, 1 port: uop0 after N, uop1 after N+1 unless stalled; `ready_o` low during uop0.
- CSR/MRET: `ready_o` low for `CSR_LAT-1` cycles after the issuing edge.
- Reset (edge with `rst_n`=0): default bundle, `valid_o`=0, `illegal_o`=0, state DECODE (`ready_o`=1 from next cycle). Reset mid-sequence discards pending uop1 and CSR wait.
- No acceptance and no stall: `valid_o`=0 next edge.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: illegal instruction is accepted, emits bubble with `valid_o`=1, `illegal_o`=1 for one cycle.
- Undefined: illegal instruction emits bubble with `valid_o`=0; `illegal_o` tied 0.

## Test plan
- Reset, then `instr_i`=32'h40335293 (SRAI x5,x6,3): `valid_o`=1, `aluop_o`=7, `sel_b_o`=1, `rf_en_o`=1 one cycle later.
- `WB_PORTS`=1, `instr_i`=32'h0040A12B: uop0 (`sel_laddr_o`=1, `sel_wb_o`=01, `rd_sel_o`=0), then uop1 (ADD, `rd_sel_o`=1, `uop_o`=1); `ready_o`=0 for exactly one cycle.
- Same as above with `WB_PORTS`=2: single bundle, `wd2_en_o`=1, `ready_o` never drops.
- `CSR_LAT`=3, `instr_i`=32'h300110F3: `csr_rd_o`=`csr_wr_o`=1, `sel_wb_o`=11, `ready_o` low 2 cycles; 32'h30200073 gives `is_mret_o`=1.
- Post-inc uop0 with `stall_i`=1 for 2 cycles, then `flush_i`=1: outputs hold while stalled, then `valid_o`=0, uop1 never emitted, `ready_o`=1.
- `instr_i`=32'hFFFFFFFF: `illegal_o`=1, `valid_o`=1 with macro; `valid_o`=0, `illegal_o`=0 without.
